instruction_encode: RTL and testbench

RV32I instruction encoder: accepts a symbolic operation, register indices and an immediate over a valid/ready stream. It range-checks and packs them into the 32-bit machine word that the core's decoder consumes. Each word is tagged with a sequential byte address for writing into instruction memory. It sits between the test-program generator / boot loader and the instruction RAM write port.

---
 rtl/rv32i_pkg.sv | 95 +++++++++
 rtl/instruction_encode_pack.sv | 110 +++++++++++
 rtl/instruction_encode.sv | 110 +++++++++++
 tb/tb_instruction_encode.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants, operation/format enums and request/decode structs.
// Used by the encoder and by the core's decoder.
package rv32i_pkg;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_ECALL, OP_EBREAK
    } op_e;

    localparam int unsigned NUM_OPS = 40;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FIXED
    } fmt_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] FENCE_WORD  = 32'h0FF0000F;
    localparam logic [31:0] ECALL_WORD  = 32'h00000073;
    localparam logic [31:0] EBREAK_WORD = 32'h00100073;

    // op is kept raw (not op_e) so out-of-range indices survive to the error check
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       shift;
        logic       err;
    } dec_t;

    function automatic dec_t mk_dec(input fmt_e f, input logic [6:0] opc,
                                    input logic [2:0] f3, input logic [6:0] f7,
                                    input logic sh);
        dec_t d;
        d.fmt    = f;
        d.opcode = opc;
        d.funct3 = f3;
        d.funct7 = f7;
        d.shift  = sh;
        d.err    = 1'b0;
        return d;
    endfunction

    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instruction_encode_pack.sv
// Op lookup + immediate range check (request side) and field packing (S1 side).
// Latency: combinational. Backpressure: none, pure logic.
// Error flag forces the packed word to zero.
module instruction_encode_pack
    import rv32i_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] imm,
    output dec_t        dec,
    input  req_t        s1_req,
    input  dec_t        s1_dec,
    output logic [31:0] instr
);

    logic        imm_bad;
    logic [11:0] imm_i;
    logic [31:0] s1_imm;

    always_comb begin
        dec     = mk_dec(FMT_R, 7'd0, 3'd0, F7_BASE, 1'b0);
        imm_bad = 1'b0;
        case (op)
            OP_LUI:    dec = mk_dec(FMT_U, OPC_LUI,    3'd0,    F7_BASE, 1'b0);
            OP_AUIPC:  dec = mk_dec(FMT_U, OPC_AUIPC,  3'd0,    F7_BASE, 1'b0);
            OP_JAL:    dec = mk_dec(FMT_J, OPC_JAL,    3'd0,    F7_BASE, 1'b0);
            OP_JALR:   dec = mk_dec(FMT_I, OPC_JALR,   3'd0,    F7_BASE, 1'b0);
            OP_BEQ:    dec = mk_dec(FMT_B, OPC_BRANCH, F3_BEQ,  F7_BASE, 1'b0);
            OP_BNE:    dec = mk_dec(FMT_B, OPC_BRANCH, F3_BNE,  F7_BASE, 1'b0);
            OP_BLT:    dec = mk_dec(FMT_B, OPC_BRANCH, F3_BLT,  F7_BASE, 1'b0);
            OP_BGE:    dec = mk_dec(FMT_B, OPC_BRANCH, F3_BGE,  F7_BASE, 1'b0);
            OP_BLTU:   dec = mk_dec(FMT_B, OPC_BRANCH, F3_BLTU, F7_BASE, 1'b0);
            OP_BGEU:   dec = mk_dec(FMT_B, OPC_BRANCH, F3_BGEU, F7_BASE, 1'b0);
            OP_LB:     dec = mk_dec(FMT_I, OPC_LOAD,   F3_B,    F7_BASE, 1'b0);
            OP_LH:     dec = mk_dec(FMT_I, OPC_LOAD,   F3_H,    F7_BASE, 1'b0);
            OP_LW:     dec = mk_dec(FMT_I, OPC_LOAD,   F3_W,    F7_BASE, 1'b0);
            OP_LBU:    dec = mk_dec(FMT_I, OPC_LOAD,   F3_BU,   F7_BASE, 1'b0);
            OP_LHU:    dec = mk_dec(FMT_I, OPC_LOAD,   F3_HU,   F7_BASE, 1'b0);
            OP_SB:     dec = mk_dec(FMT_S, OPC_STORE,  F3_B,    F7_BASE, 1'b0);
            OP_SH:     dec = mk_dec(FMT_S, OPC_STORE,  F3_H,    F7_BASE, 1'b0);
            OP_SW:     dec = mk_dec(FMT_S, OPC_STORE,  F3_W,    F7_BASE, 1'b0);
            OP_ADDI:   dec = mk_dec(FMT_I, OPC_OP_IMM, F3_ADD,  F7_BASE, 1'b0);
            OP_SLTI:   dec = mk_dec(FMT_I, OPC_OP_IMM, F3_SLT,  F7_BASE, 1'b0);
            OP_SLTIU:  dec = mk_dec(FMT_I, OPC_OP_IMM, F3_SLTU, F7_BASE, 1'b0);
            OP_XORI:   dec = mk_dec(FMT_I, OPC_OP_IMM, F3_XOR,  F7_BASE, 1'b0);
            OP_ORI:    dec = mk_dec(FMT_I, OPC_OP_IMM, F3_OR,   F7_BASE, 1'b0);
            OP_ANDI:   dec = mk_dec(FMT_I, OPC_OP_IMM, F3_AND,  F7_BASE, 1'b0);
            OP_SLLI:   dec = mk_dec(FMT_I, OPC_OP_IMM, F3_SLL,  F7_BASE, 1'b1);
            OP_SRLI:   dec = mk_dec(FMT_I, OPC_OP_IMM, F3_SR,   F7_BASE, 1'b1);
            OP_SRAI:   dec = mk_dec(FMT_I, OPC_OP_IMM, F3_SR,   F7_ALT,  1'b1);
            OP_ADD:    dec = mk_dec(FMT_R, OPC_OP,     F3_ADD,  F7_BASE, 1'b0);
            OP_SUB:    dec = mk_dec(FMT_R, OPC_OP,     F3_ADD,  F7_ALT,  1'b0);
            OP_SLL:    dec = mk_dec(FMT_R, OPC_OP,     F3_SLL,  F7_BASE, 1'b0);
            OP_SLT:    dec = mk_dec(FMT_R, OPC_OP,     F3_SLT,  F7_BASE, 1'b0);
            OP_SLTU:   dec = mk_dec(FMT_R, OPC_OP,     F3_SLTU, F7_BASE, 1'b0);
            OP_XOR:    dec = mk_dec(FMT_R, OPC_OP,     F3_XOR,  F7_BASE, 1'b0);
            OP_SRL:    dec = mk_dec(FMT_R, OPC_OP,     F3_SR,   F7_BASE, 1'b0);
            OP_SRA:    dec = mk_dec(FMT_R, OPC_OP,     F3_SR,   F7_ALT,  1'b0);
            OP_OR:     dec = mk_dec(FMT_R, OPC_OP,     F3_OR,   F7_BASE, 1'b0);
            OP_AND:    dec = mk_dec(FMT_R, OPC_OP,     F3_AND,  F7_BASE, 1'b0);
            OP_FENCE:  dec = mk_dec(FMT_FIXED, OPC_MISC_MEM, 3'd0, F7_BASE, 1'b0);
            OP_ECALL:  dec = mk_dec(FMT_FIXED, OPC_SYSTEM,   3'd0, F7_BASE, 1'b0);
            OP_EBREAK: dec = mk_dec(FMT_FIXED, OPC_SYSTEM,   3'd0, F7_BASE, 1'b0);
            default:   dec.err = 1'b1;
        endcase

        case (dec.fmt)
            FMT_I:   imm_bad = dec.shift ? (|imm[31:5]) : !in_range(imm, -2048, 2047);
            FMT_S:   imm_bad = !in_range(imm, -2048, 2047);
            FMT_B:   imm_bad = !in_range(imm, -4096, 4094) || imm[0];
            FMT_J:   imm_bad = !in_range(imm, -1048576, 1048574) || imm[0];
            FMT_U:   imm_bad = |imm[11:0];
            default: imm_bad = 1'b0;
        endcase
        if (imm_bad) begin
            dec.err = 1'b1;
        end
    end

    assign s1_imm = s1_req.imm;

    always_comb begin
        instr = '0;
        // shifts reuse the I immediate slot: funct7 on top, shamt below
        imm_i = s1_dec.shift ? {s1_dec.funct7, s1_imm[4:0]} : s1_imm[11:0];
        case (s1_dec.fmt)
            FMT_R: instr = {s1_dec.funct7, s1_req.rs2, s1_req.rs1, s1_dec.funct3,
                            s1_req.rd, s1_dec.opcode};
            FMT_I: instr = {imm_i, s1_req.rs1, s1_dec.funct3, s1_req.rd, s1_dec.opcode};
            FMT_S: instr = {s1_imm[11:5], s1_req.rs2, s1_req.rs1, s1_dec.funct3,
                            s1_imm[4:0], s1_dec.opcode};
            FMT_B: instr = {s1_imm[12], s1_imm[10:5], s1_req.rs2, s1_req.rs1, s1_dec.funct3,
                            s1_imm[4:1], s1_imm[11], s1_dec.opcode};
            FMT_U: instr = {s1_imm[31:12], s1_req.rd, s1_dec.opcode};
            FMT_J: instr = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                            s1_req.rd, s1_dec.opcode};
            FMT_FIXED: begin
                case (s1_req.op)
                    OP_FENCE:  instr = FENCE_WORD;
                    OP_EBREAK: instr = EBREAK_WORD;
                    default:   instr = ECALL_WORD;
                endcase
            end
            default: instr = '0;
        endcase
        if (s1_dec.err) begin
            instr = '0;
        end
    end

endmodule

// File: rtl/instruction_encode.sv
// RV32I encoder: symbolic request -> 32-bit word tagged with a sequential byte address.
// Latency: 2 cycles (S1 decode/check, S2 packed output), 1 word per cycle.
// Backpressure: both stages shift together; in_ready = !s1_valid || !s2_valid || out_ready.
module instruction_encode
    import rv32i_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    req_t              in_req;
    dec_t              in_dec;
    logic              s1_valid;
    req_t              s1_req;
    dec_t              s1_dec;
    logic [ADDR_W-1:0] s1_addr;
    logic [31:0]       s1_word;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] slot_addr;
    logic              s1_load;
    logic              s2_load;
    logic              accept;

    assign in_req = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

    instruction_encode_pack u_pack (
        .op     (in_op),
        .imm    (in_imm),
        .dec    (in_dec),
        .s1_req (s1_req),
        .s1_dec (s1_dec),
        .instr  (s1_word)
    );

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && s1_load;

    // a clear coinciding with an accept restarts numbering at that very request
    assign slot_addr = clear ? BASE_ADDR : addr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_req   <= '0;
            s1_dec   <= '0;
            s1_addr  <= BASE_ADDR;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_req  <= in_req;
                s1_dec  <= in_dec;
                s1_addr <= slot_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BASE_ADDR;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= s1_word;
                out_addr  <= s1_addr;
                out_err   <= s1_dec.err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt <= BASE_ADDR;
        end else if (accept) begin
            addr_cnt <= slot_addr + ADDR_W'(4);
        end else if (clear) begin
            addr_cnt <= BASE_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && out_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instruction_encode.sv
// Directed bench for instruction_encode: hand-encoded words, error cases, backpressure,
// clear, address wrap (second 4-bit-address instance) and mid-stream reset.
module tb_instruction_encode;
    import rv32i_pkg::*;

    localparam logic [11:0] BASE = 12'h100;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, out_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [11:0] out_addr;
    logic [7:0]  err_cnt;
    logic        w_in_ready, w_out_valid, w_out_err;
    logic [31:0] w_out_instr;
    logic [3:0]  w_out_addr;
    logic [7:0]  w_err_cnt;

    always #5 clk = ~clk;

    instruction_encode #(.ADDR_W(12), .BASE_ADDR(BASE)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
    );

    instruction_encode #(.ADDR_W(4), .BASE_ADDR(4'h0)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_out_instr),
        .out_addr(w_out_addr), .out_err(w_out_err), .err_cnt(w_err_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] got_instr[$], exp_instr[$];
    logic [11:0] got_addr[$],  exp_addr[$];
    logic        got_err[$],   exp_err[$];
    logic [3:0]  got_waddr[$], exp_waddr[$];
    logic [11:0] next_addr = BASE;
    logic [3:0]  wnext = 4'h0;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        err;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_instr.push_back(out_instr);
            got_addr.push_back(out_addr);
            got_err.push_back(out_err);
        end
        if (!rst && w_out_valid && out_ready) got_waddr.push_back(w_out_addr);
    end

    task automatic push_exp(input logic [31:0] w, input logic e, input logic clr);
        logic [11:0] a;
        logic [3:0]  wa;
        a  = clr ? BASE : next_addr;
        wa = clr ? 4'h0 : wnext;
        exp_instr.push_back(w);
        exp_err.push_back(e);
        exp_addr.push_back(a);
        exp_waddr.push_back(wa);
        next_addr = a + 12'd4;
        wnext     = wa + 4'd4;
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] w,
                        input logic e, input logic clr, input logic keep);
        bit acc = 1'b0;
        int n = 0;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        clear = clr; in_valid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        if (!acc) chk("send_accept", 32'd0, 32'd1);
        else if (keep) push_exp(w, e, clr);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        int m;
        out_ready = 1'b1;
        while (got_instr.size() < exp_instr.size() && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk({tag, "_count"}, 32'(got_instr.size()), 32'(exp_instr.size()));
        chk({tag, "_wcount"}, 32'(got_waddr.size()), 32'(exp_waddr.size()));
        m = (got_instr.size() < exp_instr.size()) ? got_instr.size() : exp_instr.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_instr%0d", tag, i), got_instr[i], exp_instr[i]);
            chk($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s_err%0d", tag, i), 32'(got_err[i]), 32'(exp_err[i]));
            if (i < got_waddr.size())
                chk($sformatf("%s_waddr%0d", tag, i), 32'(got_waddr[i]), 32'(exp_waddr[i]));
        end
        got_instr.delete(); exp_instr.delete();
        got_addr.delete();  exp_addr.delete();
        got_err.delete();   exp_err.delete();
        got_waddr.delete(); exp_waddr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'(BASE));
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // latency: addi x1, x0, 5 presented now, visible two edges later
        in_op = OP_ADDI; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("lat_vld_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_vld", 32'(out_valid), 32'd1);
        chk("lat_instr", out_instr, 32'h00500093);
        chk("lat_addr", 32'(out_addr), 32'(BASE));
        chk("lat_err", 32'(out_err), 32'd0);
        push_exp(32'h00500093, 1'b0, 1'b0);

        vecs.push_back('{OP_BEQ,    5'd7, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0});
        vecs.push_back('{OP_LUI,    5'd5, 5'd4, 5'd6, 32'h12345000, 32'h123452B7, 1'b0});
        vecs.push_back('{OP_SRAI,   5'd3, 5'd3, 5'd9, 32'd4,        32'h4041D193, 1'b0});
        vecs.push_back('{OP_ADD,    5'd3, 5'd1, 5'd2, 32'h00000055, 32'h002081B3, 1'b0});
        vecs.push_back('{OP_SUB,    5'd1, 5'd2, 5'd3, 32'd0,        32'h403100B3, 1'b0});
        vecs.push_back('{OP_SW,     5'd7, 5'd1, 5'd2, 32'd8,        32'h0020A423, 1'b0});
        vecs.push_back('{OP_JAL,    5'd1, 5'd9, 5'd9, 32'd8,        32'h008000EF, 1'b0});
        vecs.push_back('{OP_LW,     5'd5, 5'd2, 5'd7, 32'hFFFFFFFC, 32'hFFC12283, 1'b0});
        vecs.push_back('{OP_ADDI,   5'd1, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0});
        vecs.push_back('{OP_BEQ,    5'd0, 5'd0, 5'd0, 32'd4094,     32'h7E000FE3, 1'b0});
        vecs.push_back('{OP_JAL,    5'd0, 5'd0, 5'd0, 32'hFFF00000, 32'h8000006F, 1'b0});
        vecs.push_back('{OP_SLLI,   5'd1, 5'd1, 5'd0, 32'd31,       32'h01F09093, 1'b0});
        vecs.push_back('{OP_FENCE,  5'd1, 5'd2, 5'd3, 32'd0,        32'h0FF0000F, 1'b0});
        vecs.push_back('{OP_ECALL,  5'd0, 5'd0, 5'd0, 32'd0,        32'h00000073, 1'b0});
        vecs.push_back('{OP_EBREAK, 5'd0, 5'd0, 5'd0, 32'd0,        32'h00100073, 1'b0});
        vecs.push_back('{OP_ADDI,   5'd1, 5'd0, 5'd0, 32'd2048,     32'd0,        1'b1});
        vecs.push_back('{OP_JAL,    5'd1, 5'd0, 5'd0, 32'd3,        32'd0,        1'b1});
        vecs.push_back('{6'd45,     5'd1, 5'd1, 5'd1, 32'd0,        32'd0,        1'b1});
        vecs.push_back('{OP_SLLI,   5'd1, 5'd1, 5'd0, 32'd32,       32'd0,        1'b1});
        vecs.push_back('{OP_BEQ,    5'd0, 5'd1, 5'd2, 32'd4096,     32'd0,        1'b1});
        vecs.push_back('{OP_LUI,    5'd5, 5'd0, 5'd0, 32'd1,        32'd0,        1'b1});
        foreach (vecs[i])
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                 vecs[i].exp, vecs[i].err, 1'b0, 1'b1);
        drain("vec");
        chk("vec_err_cnt", 32'(err_cnt), 32'd6);

        // backpressure: sink stalled for three cycles while four addi are pushed
        fork
            begin
                send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1'b0, 1'b0, 1'b1);
                send(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 1'b0, 1'b0, 1'b1);
                send(OP_ADDI, 5'd3, 5'd0, 5'd0, 32'd3, 32'h00300193, 1'b0, 1'b0, 1'b1);
                send(OP_ADDI, 5'd4, 5'd0, 5'd0, 32'd4, 32'h00400213, 1'b0, 1'b0, 1'b1);
            end
            begin
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                chk("bp_held_instr", out_instr, 32'h00100093);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("bp");

        // err_cnt saturates at 255
        for (int i = 0; i < 255; i++)
            send(6'd45, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        drain("sat");
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        // clear with accept restarts numbering; 4-bit instance wraps on the 5th word
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h00100093, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            send(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 32'h00200113, 1'b0, 1'b0, 1'b1);
        drain("clr");
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);

        // reset with two words in flight
        send(6'd45, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        drain("pre_rst");
        chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
        out_ready = 1'b0;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);
        send(6'd45,   5'd1, 5'd0, 5'd0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        next_addr = BASE;
        wnext     = 4'h0;
        out_ready = 1'b1;
        chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_no_valid%0d", i), 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 1'b0, 1'b1);
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
